// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the derived data-phase state used by the
// SRAM slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    localparam logic HRESP_OKAY = 1'b0;

    // Which data phase the bus is in; the posted-write buffer is tracked separately.
    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_RD_DATA = 2'd1,
        PH_WR_DATA = 2'd2
    } phase_e;

endpackage

// File: rtl/ahb_byte_strobe.sv
// 64-bit AHB byte-lane strobe from transfer size and low address bits.
// Misaligned low bits are ignored; sizes of a dword or larger select all lanes.
module ahb_byte_strobe
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [2:0] haddr_lo,
    output logic [7:0] strb
);

    logic is_byte;
    logic is_half;
    logic is_word;
    logic is_wide;

    assign is_byte = (hsize == HSIZE_BYTE);
    assign is_half = (hsize == HSIZE_HALF);
    assign is_word = (hsize == HSIZE_WORD);
    assign is_wide = (hsize >= HSIZE_DWORD);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            localparam logic [2:0] LANE = gi[2:0];
            assign strb[gi] = is_wide
                            | (is_word && (haddr_lo[2]   == LANE[2]))
                            | (is_half && (haddr_lo[2:1] == LANE[2:1]))
                            | (is_byte && (haddr_lo      == LANE));
        end
    endgenerate

endmodule

// File: rtl/ahb_sram64_ctrl.sv
// Zero-wait-state 64-bit AHB-Lite slave in front of a 1-cycle-latency SRAM,
// with a one-entry posted-write buffer and read-after-write forwarding.
module ahb_sram64_ctrl
    import ahb_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 64
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            HSEL,
    input  logic [31:0]     HADDR,
    input  logic [1:0]      HTRANS,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [DW-1:0]   HWDATA,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic            HRESP,
    output logic [DW-1:0]   HRDATA,
    output logic            SRAMCS,
    output logic [DW/8-1:0] SRAMWE,
    output logic [AW-1:0]   SRAMADDR,
    output logic [DW-1:0]   SRAMWDATA,
    input  logic [DW-1:0]   SRAMRDATA
);

    localparam int NB = DW / 8;

    logic          xfer;
    logic          rd_ap;
    logic          wr_ap;
    logic          drain;
    logic          addr_hit;
    logic [AW-1:0] ap_addr;
    logic [NB-1:0] ap_strb;
    logic [DW-1:0] rd_merged;
    phase_e        phase;

    logic          rd_dph_reg,   rd_dph_next;
    logic          wr_dph_reg,   wr_dph_next;
    logic          buf_pend_reg, buf_pend_next;
    logic [AW-1:0] buf_addr_reg, buf_addr_next;
    logic [NB-1:0] buf_strb_reg, buf_strb_next;
    logic [DW-1:0] buf_data_reg, buf_data_next;
    logic [NB-1:0] hit_mask_reg, hit_mask_next;

    logic unused_bits;
    assign unused_bits = &{1'b0, HADDR[31:AW+3], HTRANS[0]};

    assign xfer    = HSEL & HREADY & HTRANS[1];
    assign rd_ap   = xfer & ~HWRITE;
    assign wr_ap   = xfer & HWRITE;
    assign ap_addr = HADDR[AW+2:3];

    // A read address phase owns the SRAM port; otherwise a pending write drains.
    assign drain    = buf_pend_reg & ~rd_ap;
    assign addr_hit = buf_pend_reg && (buf_addr_reg == ap_addr);

    assign phase = rd_dph_reg ? PH_RD_DATA :
                   wr_dph_reg ? PH_WR_DATA : PH_IDLE;

    ahb_byte_strobe u_strobe (
        .hsize    (HSIZE),
        .haddr_lo (HADDR[2:0]),
        .strb     (ap_strb)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_fwd
            assign rd_merged[gi*8 +: 8] = hit_mask_reg[gi] ? buf_data_reg[gi*8 +: 8]
                                                           : SRAMRDATA[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_dph_reg   <= 1'b0;
            wr_dph_reg   <= 1'b0;
            buf_pend_reg <= 1'b0;
            buf_addr_reg <= '0;
            buf_strb_reg <= '0;
            buf_data_reg <= '0;
            hit_mask_reg <= '0;
        end else begin
            rd_dph_reg   <= rd_dph_next;
            wr_dph_reg   <= wr_dph_next;
            buf_pend_reg <= buf_pend_next;
            buf_addr_reg <= buf_addr_next;
            buf_strb_reg <= buf_strb_next;
            buf_data_reg <= buf_data_next;
            hit_mask_reg <= hit_mask_next;
        end
    end

    always_comb begin
        rd_dph_next   = rd_ap;
        wr_dph_next   = wr_ap;
        buf_pend_next = buf_pend_reg;
        buf_addr_next = buf_addr_reg;
        buf_strb_next = buf_strb_reg;
        buf_data_next = buf_data_reg;
        hit_mask_next = '0;

        if (drain) begin
            buf_pend_next = 1'b0;
        end
        // A new write reloads the buffer even in the cycle its predecessor drains.
        if (wr_ap) begin
            buf_pend_next = 1'b1;
            buf_addr_next = ap_addr;
            buf_strb_next = ap_strb;
        end
        if (phase == PH_WR_DATA) begin
            buf_data_next = HWDATA;
        end
        if (rd_ap && addr_hit) begin
            hit_mask_next = buf_strb_reg;
        end
    end

    always_comb begin
        SRAMCS    = 1'b0;
        SRAMWE    = '0;
        SRAMADDR  = ap_addr;
        // During the buffered write's own data phase its data is still on HWDATA.
        SRAMWDATA = (phase == PH_WR_DATA) ? HWDATA : buf_data_reg;
        HRDATA    = '0;

        if (rd_ap) begin
            SRAMCS = 1'b1;
        end else if (drain) begin
            SRAMCS   = 1'b1;
            SRAMWE   = buf_strb_reg;
            SRAMADDR = buf_addr_reg;
        end

        if (phase == PH_RD_DATA) begin
            HRDATA = rd_merged;
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = HRESP_OKAY;

endmodule

// File: tb/tb_ahb_sram64_ctrl.sv
// Directed and randomized bench: an ideal byte-addressed memory predicts every
// read, and a behavioural SRAM is compared against it after the bus goes quiet.
module tb_ahb_sram64_ctrl;
    import ahb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 64;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [63:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [63:0]   HRDATA;
    logic          SRAMCS;
    logic [7:0]    SRAMWE;
    logic [AW-1:0] SRAMADDR;
    logic [63:0]   SRAMWDATA;
    logic [63:0]   SRAMRDATA;

    ahb_sram64_ctrl #(.AW(AW), .DW(DW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .SRAMCS    (SRAMCS),
        .SRAMWE    (SRAMWE),
        .SRAMADDR  (SRAMADDR),
        .SRAMWDATA (SRAMWDATA),
        .SRAMRDATA (SRAMRDATA)
    );

    always #5 HCLK = ~HCLK;

    // Behavioural synchronous SRAM with byte write enables.
    logic [63:0] mem [0:(1<<AW)-1] = '{default: 64'h0};
    logic [63:0] sram_q = 64'h0;
    logic [63:0] sram_w;
    assign SRAMRDATA = sram_q;

    always @(posedge HCLK) begin
        if (SRAMCS) begin
            if (SRAMWE == 8'h00) begin
                sram_q <= mem[SRAMADDR];
            end else begin
                sram_w = mem[SRAMADDR];
                for (int i = 0; i < 8; i++)
                    if (SRAMWE[i]) sram_w[i*8 +: 8] = SRAMWDATA[i*8 +: 8];
                mem[SRAMADDR] <= sram_w;
            end
        end
    end

    // Ideal memory: writes land when their data is presented.
    logic [63:0] golden [0:(1<<AW)-1] = '{default: 64'h0};

    int checks = 0;
    int errors = 0;

    logic          rd_pend = 1'b0;
    logic [63:0]   rd_exp  = 64'h0;
    logic          wr_pend = 1'b0;
    logic [31:0]   wr_addr = 32'h0;
    logic [2:0]    wr_size = 3'd0;
    logic [63:0]   wr_data = 64'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_strb(input logic [2:0] size, input logic [2:0] lo);
        int n;
        int first;
        logic [7:0] m;
        n     = 1 << ((size > 3'd3) ? 3 : int'(size));
        first = (int'(lo) / n) * n;
        m     = 8'((1 << n) - 1);
        return m << first;
    endfunction

    task automatic golden_write(input logic [31:0] addr, input logic [2:0] size, input logic [63:0] data);
        logic [7:0]    s;
        logic [AW-1:0] w;
        s = exp_strb(size, addr[2:0]);
        w = addr[AW+2:3];
        for (int i = 0; i < 8; i++)
            if (s[i]) golden[w][i*8 +: 8] = data[i*8 +: 8];
    endtask

    // One bus cycle: check the previous data phase, then present a new address phase.
    task automatic step(input logic sel, input logic rdy, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [2:0] size, input logic [63:0] wdata);
        logic x;
        @(negedge HCLK);
        if (rd_pend) chk("hrdata", HRDATA, rd_exp);
        else         chk("hrdata_idle", HRDATA, 64'h0);
        chk("hreadyout", {63'h0, HREADYOUT}, 64'h1);
        chk("hresp", {63'h0, HRESP}, 64'h0);
        HSEL   = sel;
        HREADY = rdy;
        HTRANS = trans;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
        HWDATA = wr_pend ? wr_data : {$urandom, $urandom};
        if (wr_pend) golden_write(wr_addr, wr_size, wr_data);
        x = sel & rdy & trans[1];
        rd_pend = x & ~wr;
        if (rd_pend) rd_exp = golden[addr[AW+2:3]];
        wr_pend = x & wr;
        wr_addr = addr;
        wr_size = size;
        wr_data = wdata;
        #1;
        $display("cycle t=%0t sel=%0b rdy=%0b trans=%0d wr=%0b addr=%h size=%0d | cs=%0b we=%h sa=%h", $time,
                 sel, rdy, trans, wr, addr, size, SRAMCS, SRAMWE, SRAMADDR);
    endtask

    task automatic wr_x(input logic [31:0] addr, input logic [2:0] size, input logic [63:0] data);
        step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, addr, size, data);
    endtask

    task automatic rd_x(input logic [31:0] addr);
        step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, addr, HSIZE_DWORD, 64'h0);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, HTRANS_IDLE, 1'b0, 32'h0, 3'd0, 64'h0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge HCLK);
        HRESETn = 1'b0;
        HSEL = 1'b0; HREADY = 1'b1; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
        HADDR = 32'h0; HSIZE = 3'd0; HWDATA = 64'h0;
        rd_pend = 1'b0;
        wr_pend = 1'b0;
        #1;
        chk("rst_cs", {63'h0, SRAMCS}, 64'h0);
        chk("rst_we", {56'h0, SRAMWE}, 64'h0);
        chk("rst_hrdata", HRDATA, 64'h0);
        chk("rst_hready", {63'h0, HREADYOUT}, 64'h1);
        chk("rst_hresp", {63'h0, HRESP}, 64'h0);
        repeat (cycles) begin
            @(negedge HCLK);
            chk("rst_hold_cs", {63'h0, SRAMCS}, 64'h0);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        chk("rst_rel_cs", {63'h0, SRAMCS}, 64'h0);
        $display("reset released t=%0t", $time);
    endtask

    initial begin
        logic [63:0] x_val;
        logic [31:0] a;

        HRESETn = 1'b0;
        HSEL = 1'b0; HREADY = 1'b1; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
        HADDR = 32'h0; HSIZE = 3'd0; HWDATA = 64'h0;
        do_reset(2);

        // Byte write then immediate read of the same word: forwarded, drain afterwards.
        wr_x(32'h13, HSIZE_BYTE, 64'h0000_0000_AB00_0000);
        rd_x(32'h10);
        chk("raw_rd_cs", {63'h0, SRAMCS}, 64'h1);
        chk("raw_rd_we", {56'h0, SRAMWE}, 64'h0);
        chk("raw_rd_addr", {52'h0, SRAMADDR}, 64'h2);
        idle();
        chk("raw_drain_we", {56'h0, SRAMWE}, 64'h08);
        chk("raw_drain_addr", {52'h0, SRAMADDR}, 64'h2);
        chk("raw_drain_b3", {56'h0, SRAMWDATA[31:24]}, 64'hAB);
        idle();

        // Dword write followed by IDLE: drains with the bus write data.
        wr_x(32'h10, HSIZE_DWORD, 64'h1122_3344_5566_7788);
        idle();
        chk("dw_cs", {63'h0, SRAMCS}, 64'h1);
        chk("dw_we", {56'h0, SRAMWE}, 64'hFF);
        chk("dw_addr", {52'h0, SRAMADDR}, 64'h2);
        chk("dw_wdata", SRAMWDATA, 64'h1122_3344_5566_7788);
        rd_x(32'h10);
        idle();

        // Back-to-back writes.
        wr_x(32'h20, HSIZE_WORD, 64'h0000_0000_DEAD_BEEF);
        wr_x(32'h26, HSIZE_HALF, 64'hCAFE_0000_0000_0000);
        chk("b2b_we0", {56'h0, SRAMWE}, 64'h0F);
        chk("b2b_addr0", {52'h0, SRAMADDR}, 64'h4);
        chk("b2b_wd0", {32'h0, SRAMWDATA[31:0]}, 64'hDEAD_BEEF);
        idle();
        chk("b2b_we1", {56'h0, SRAMWE}, 64'hC0);
        chk("b2b_addr1", {52'h0, SRAMADDR}, 64'h4);
        chk("b2b_wd1", {48'h0, SRAMWDATA[63:48]}, 64'hCAFE);
        rd_x(32'h20);
        idle();

        // Buffer held across a run of reads to another word.
        wr_x(32'h40, HSIZE_DWORD, 64'h0F0E_0D0C_0B0A_0908);
        for (int i = 0; i < 5; i++) begin
            rd_x(32'h48);
            chk("hold_we", {56'h0, SRAMWE}, 64'h0);
            chk("hold_addr", {52'h0, SRAMADDR}, 64'h9);
        end
        idle();
        chk("hold_drain_we", {56'h0, SRAMWE}, 64'hFF);
        chk("hold_drain_addr", {52'h0, SRAMADDR}, 64'h8);
        chk("hold_drain_wd", SRAMWDATA, 64'h0F0E_0D0C_0B0A_0908);

        // HREADY low in the address phase: no transfer.
        step(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_DWORD, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("nrdy_cs", {63'h0, SRAMCS}, 64'h0);
        idle();
        chk("nrdy_cs2", {63'h0, SRAMCS}, 64'h0);
        rd_x(32'h40);
        idle();

        // Reset while a posted write is pending.
        x_val = 64'h5555_6666_7777_8888;
        wr_x(32'h80, HSIZE_DWORD, x_val);
        idle();
        idle();
        wr_x(32'h80, HSIZE_DWORD, 64'h9999_AAAA_BBBB_CCCC);
        do_reset(2);
        chk("rst_mem", mem[16], x_val);
        rd_x(32'h80);
        idle();

        // Randomized traffic over eight words, with aliased upper address bits.
        for (int i = 0; i < 400; i++) begin
            a = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 7)) << 3) | 32'($urandom_range(0, 7));
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 4)), {$urandom, $urandom});
        end
        idle();
        idle();
        idle();
        for (int i = 0; i < 17; i++) chk("final_mem", mem[i], golden[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
